// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a byte stream into 32-bit words,
// writes them from address 0 and holds the CPU until the checksum matches.
module imem_loader #(
    parameter int BITSIZE = 32,
    parameter int REGSIZE = 64,
    parameter int COUNTW  = 8
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               Start,
    input  logic [7:0]         ByteIn,
    input  logic               ByteValid,
    output logic               ByteReady,
    output logic               MemWrite,
    output logic [REGSIZE-1:0] MemAddress,
    output logic [BITSIZE-1:0] MemData,
    output logic               CpuHold,
    output logic               Done,
    output logic               Error,
    output logic [COUNTW-1:0]  WordsLoaded
);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [23:0]          shift_q, shift_d;
    logic [BITSIZE-1:0]   data_q, data_d;
    logic [REGSIZE-1:0]   addr_q, addr_d;
    logic [COUNTW-1:0]    words_q, words_d;
    logic [COUNTW-1:0]    num_q, num_d;
    logic [7:0]           acc_q, acc_d;
    logic [1:0]           bcnt_q, bcnt_d;
    logic                 take;

    // Ready is a pure function of state so the source never sees a loop.
    assign ByteReady   = (state_q == COUNT) || (state_q == DATA)
                      || (state_q == CHECK);
    assign take        = ByteValid && ByteReady;
    assign MemWrite    = (state_q == WRITE);
    assign MemAddress  = addr_q;
    assign MemData     = data_q;
    assign Done        = (state_q == DONE);
    assign Error       = (state_q == ERROR);
    assign CpuHold     = (state_q == COUNT) || (state_q == DATA)
                      || (state_q == WRITE) || (state_q == CHECK)
                      || (state_q == ERROR);
    assign WordsLoaded = words_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            shift_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            words_q <= '0;
            num_q   <= '0;
            acc_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            num_q   <= num_d;
            acc_q   <= acc_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        addr_d  = addr_q;
        words_d = words_q;
        num_d   = num_q;
        acc_d   = acc_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (Start) begin
                    state_d = COUNT;
                    addr_d  = '0;
                    words_d = '0;
                    acc_d   = '0;
                    bcnt_d  = '0;
                end
            end
            COUNT: begin
                if (take) begin
                    if ((ByteIn == 8'd0) || (int'(ByteIn) > REGSIZE)) begin
                        state_d = ERROR;
                    end else begin
                        num_d   = COUNTW'(ByteIn);
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (take) begin
                    shift_d = {shift_q[15:0], ByteIn};
                    acc_d   = acc_q ^ ByteIn;
                    bcnt_d  = bcnt_q + 2'd1;
                    // Word leaves the shifter on its last byte so MemData is
                    // stable for the whole WRITE cycle and after it.
                    if (bcnt_q == 2'd3) begin
                        data_d  = {shift_q, ByteIn};
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d  = addr_q + REGSIZE'(1);
                words_d = words_q + COUNTW'(1);
                if ((words_q + COUNTW'(1)) == num_q) begin
                    state_d = CHECK;
                end else begin
                    state_d = DATA;
                end
            end
            CHECK: begin
                if (take) begin
                    state_d = (ByteIn == acc_q) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction memory, which exposes only an asynchronous read port.
- Receives a byte stream over a valid/ready handshake and assembles 32-bit instruction words, MSB byte first.
- Writes each word through the instruction memory's write port at consecutive word addresses starting at 0.
- Holds the CPU off (CpuHold) while loading, then releases it once the image passes a checksum.

Parameters:
BITSIZE, 32, instruction word width; fixed at 4 bytes.
REGSIZE, 64, address width and memory depth in words.
COUNTW, 8, width of the WordsLoaded counter; must hold REGSIZE.

Ports:
CLOCK  in  1  system clock, rising edge.
RESET_N  in  1  asynchronous, active-low reset.
Start  in  1  one-cycle pulse that begins a load.
ByteIn  in  8  stream data byte.
ByteValid  in  1  ByteIn is valid.
ByteReady  out  1  loader accepts ByteIn this cycle.
MemWrite  out  1  instruction memory write strobe.
MemAddress  out  REGSIZE  word address for the write.
MemData  out  BITSIZE  instruction word to write.
CpuHold  out  1  CPU must not fetch while this is high.
Done  out  1  image loaded and checksum matched.
Error  out  1  load aborted.
WordsLoaded  out  COUNTW  number of words written in the current load.

Behaviour:
- Reset (asynchronous, RESET_N low): state IDLE; all outputs 0, MemAddress 0, MemData 0; internal XOR accumulator and byte counter cleared.
- Byte transfer: occurs on a rising edge where ByteValid and ByteReady are both 1. ByteReady depends only on state, never on ByteValid.
- States:
  IDLE: ByteReady=0. Start goes to COUNT, sets CpuHold=1, clears Done, Error, WordsLoaded, MemAddress and the accumulator.
  COUNT: ByteReady=1. The accepted byte is N. If N==0 or N>REGSIZE, go to ERROR; otherwise latch N and go to DATA.
  DATA: ByteReady=1. Each byte shifts in: word = {word[23:0], byte}. Each byte is XORed into the accumulator. The 4th byte of a word goes to WRITE.
  WRITE: ByteReady=0, MemWrite=1 for exactly one cycle with the assembled MemData at the current MemAddress. On leaving WRITE, MemAddress and WordsLoaded increment. If WordsLoaded+1==N go to CHECK, else back to DATA.
  CHECK: ByteReady=1. If the accepted byte equals the accumulator, go to DONE; otherwise go to ERROR. The count byte is not part of the checksum.
  DONE: Done=1, CpuHold=0, ByteReady=0.
  ERROR: Error=1, CpuHold=1, ByteReady=0.
- Latency: MemWrite is high in the cycle immediately after the edge that accepts the 4th byte. Peak throughput is 4 bytes per 5 cycles.
- MemAddress and MemData hold their last value outside WRITE. MemWrite is high only in WRITE.
- Start is ignored in COUNT, DATA, WRITE and CHECK. Start in DONE or ERROR restarts the load exactly as from IDLE.
- ByteValid with ByteReady=0 is not consumed; the source must hold the byte.
- Reset mid-load returns to the reset state immediately. Words already written stay in memory; CpuHold drops to 0.
- MemAddress wraps never: N≤REGSIZE bounds the last address to REGSIZE-1.

Test Plan:
1. Single word: Start; bytes 01,F8,00,00,1F, checksum E7 -> one MemWrite pulse, Address 0, Data 0xF800001F; then Done=1, CpuHold=0, WordsLoaded=1.
2. Zero count: Start; byte 00 -> Error=1, CpuHold=1, no MemWrite, ByteReady=0 afterward.
3. Bad checksum: same as scenario 1 but checksum E6 -> the word is written at 0, then Error=1, Done=0, CpuHold=1.
4. Backpressure and gaps: 2 words 0xF2800CDE and 0xCB1E0043, ByteValid toggling every cycle -> ByteReady=0 in each WRITE cycle; writes at Address 0 then 1; correct checksum gives Done.
5. Reset mid-DATA after 2 data bytes -> all outputs 0 immediately; a fresh scenario-1 load then succeeds.
6. Full depth: count 64 (0x40), 256 bytes -> 64 writes, last Address 63, WordsLoaded=64, Done. Count 65 -> Error, no writes.
